// File: rtl/uart_ep_packer.sv
// Double-banked UART-to-EP2 packet builder: fills one bank while the other drains.
// Optional drop counter enabled by defining UART_EP_PACKER_DROPCNT_EN.
module uart_ep_packer #(
    parameter int          DEPTH   = 64,
    parameter logic [15:0] TIMEOUT = 16'd600
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dval,
    input  logic [7:0]  i_data,
    input  logic [9:0]  i_max_len,
    output logic        o_dval,
    output logic [7:0]  o_data,
    output logic        o_last,
    input  logic        i_tx_rdy,
    output logic        o_drop,
    output logic [15:0] o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [7:0]    mem [0:2*DEPTH-1];
    state_t        state;
    logic          fill_sel;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] drain_len;
    logic [15:0]   timer;

    logic [CW-1:0] max_len;
    logic          wr_room;
    logic          wr_take;
    logic          wr_spill;
    logic          drop;
    logic          handoff;
    logic [CW-1:0] handoff_len;
    logic [CW-1:0] rd_next;
    logic [AW:0]   wr_addr;
    logic          transfer;

    always_comb begin
        max_len = CW'(DEPTH);
        if (i_max_len != '0 && i_max_len <= 10'(DEPTH))
            max_len = CW'(i_max_len);
    end

    // >= rather than == so a limit lowered below wr_cnt mid-fill still flushes.
    always_comb begin
        wr_room     = (wr_cnt < max_len);
        wr_take     = i_dval & wr_room;
        handoff     = (state == IDLE) && (wr_cnt != '0) &&
                      ((wr_cnt >= max_len) || (timer == TIMEOUT));
        wr_spill    = i_dval & ~wr_room & handoff;
        drop        = i_dval & ~wr_room & ~handoff;
        handoff_len = wr_cnt + CW'(wr_take);
        rd_next     = rd_cnt + 1'b1;
        transfer    = o_dval & i_tx_rdy;
        wr_addr     = wr_take ? {fill_sel, wr_cnt[AW-1:0]} : {~fill_sel, AW'(0)};
    end

    always_ff @(posedge i_clk) begin
        if (wr_take | wr_spill)
            mem[wr_addr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            fill_sel  <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            drain_len <= '0;
            timer     <= '0;
            o_dval    <= 1'b0;
            o_data    <= 8'h00;
            o_last    <= 1'b0;
            o_drop    <= 1'b0;
        end else begin
            o_drop <= drop;

            if (handoff) begin
                fill_sel <= ~fill_sel;
                wr_cnt   <= CW'(wr_spill);
                timer    <= '0;
            end else if (wr_take) begin
                wr_cnt <= wr_cnt + 1'b1;
                timer  <= '0;
            end else if (wr_cnt == '0) begin
                timer <= '0;
            end else if (timer != TIMEOUT) begin
                timer <= timer + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (handoff) begin
                        state     <= DRAIN;
                        drain_len <= handoff_len;
                        rd_cnt    <= '0;
                        o_dval    <= 1'b1;
                        o_data    <= mem[{fill_sel, AW'(0)}];
                        o_last    <= (handoff_len == CW'(1));
                    end
                end
                DRAIN: begin
                    if (transfer) begin
                        if (o_last) begin
                            state  <= IDLE;
                            rd_cnt <= '0;
                            o_dval <= 1'b0;
                            o_data <= 8'h00;
                            o_last <= 1'b0;
                        end else begin
                            rd_cnt <= rd_next;
                            o_data <= mem[{~fill_sel, rd_next[AW-1:0]}];
                            o_last <= (rd_next == drain_len - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_EP_PACKER_DROPCNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_drop_cnt <= '0;
        else if (drop && o_drop_cnt != 16'hFFFF)
            o_drop_cnt <= o_drop_cnt + 16'd1;
    end
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_ep_packer.sv
// Directed bench for uart_ep_packer: latency, timeout flush, overflow drops, reset, stalls.
module tb_uart_ep_packer;
    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_dval;
    logic [7:0]  i_data;
    logic [9:0]  i_max_len;
    logic        o_dval;
    logic [7:0]  o_data;
    logic        o_last;
    logic        i_tx_rdy;
    logic        o_drop;
    logic [15:0] o_drop_cnt;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

`ifdef UART_EP_PACKER_DROPCNT_EN
    localparam logic [15:0] EXP_DROPS = 16'd2;
`else
    localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

    always #5 clk = ~clk;

    uart_ep_packer #(.DEPTH(64), .TIMEOUT(16'd600)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_dval(i_dval), .i_data(i_data),
        .i_max_len(i_max_len), .o_dval(o_dval), .o_data(o_data), .o_last(o_last),
        .i_tx_rdy(i_tx_rdy), .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_burst(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            i_dval = 1'b1;
            i_data = base + 8'(i);
            exp_q.push_back(base + 8'(i));
            tick;
        end
        i_dval = 1'b0;
    endtask

    // Transfers `count` bytes of a `len`-byte packet, checking data and o_last against exp_q.
    task automatic drain(input int len, input int count, input bit rnd);
        logic [7:0] d;
        logic       l;
        logic [7:0] e;
        for (int k = 0; k < count; k++) begin
            int w = 0;
            int s = 0;
            while (!o_dval && w < 2000) begin
                tick;
                w++;
            end
            check("dval_wait", 16'(o_dval), 16'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            do begin
                i_tx_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (s > 50) i_tx_rdy = 1'b1;
                d = o_data;
                l = o_last;
                tick;
                s++;
                if (!i_tx_rdy) begin
                    check("stall_dval", 16'(o_dval), 16'd1);
                    check("stall_data", 16'(o_data), 16'(d));
                    check("stall_last", 16'(o_last), 16'(l));
                end
            end while (!i_tx_rdy);
            check("data", 16'(d), 16'(e));
            check("last", 16'(l), 16'(k == len - 1));
        end
        i_tx_rdy = 1'b1;
        if (count == len)
            check("idle_after_pkt", 16'(o_dval), 16'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int drops;

        i_reset   = 1'b1;
        i_dval    = 1'b0;
        i_data    = 8'h00;
        i_max_len = 10'd64;
        i_tx_rdy  = 1'b1;
        tick;
        tick;
        check("rst_dval", 16'(o_dval), 16'd0);
        check("rst_last", 16'(o_last), 16'd0);
        check("rst_drop", 16'(o_drop), 16'd0);
        check("rst_data", 16'(o_data), 16'h00);
        check("rst_dropcnt", o_drop_cnt, 16'd0);
        i_reset = 1'b0;
        tick;

        // Full 64-byte packet: o_dval first high two cycles after the last write.
        send_burst(8'h00, 64);
        check("lat_full_n1", 16'(o_dval), 16'd0);
        tick;
        check("lat_full_n2", 16'(o_dval), 16'd1);
        drain(64, 64, 1'b0);

        // Partial packet flushed by the idle timer.
        send_burst(8'hA1, 5);
        w = 0;
        while (!o_dval && w < 700) begin
            tick;
            w++;
        end
        check("lat_timeout", 16'(w), 16'd601);
        drain(5, 5, 1'b0);

        // Overflow while stalled: byte 65 lands on the handoff cycle, 129/130 dropped.
        i_tx_rdy = 1'b0;
        drops = 0;
        for (int i = 0; i < 130; i++) begin
            i_dval = 1'b1;
            i_data = 8'(i);
            if (i < 128) exp_q.push_back(8'(i));
            tick;
            drops += int'(o_drop);
        end
        i_dval = 1'b0;
        tick;
        drops += int'(o_drop);
        check("drop_pulses", 16'(drops), 16'd2);
        check("drop_cnt", o_drop_cnt, EXP_DROPS);
        check("stalled_dval", 16'(o_dval), 16'd1);
        check("stalled_data", 16'(o_data), 16'h00);
        drain(64, 64, 1'b0);
        drain(64, 64, 1'b0);

        // Lowering the limit below the held count flushes on the next cycle.
        send_burst(8'h50, 10);
        i_max_len = 10'd4;
        w = 0;
        while (!o_dval && w < 20) begin
            tick;
            w++;
        end
        check("lat_maxlen_shrink", 16'(w), 16'd1);
        i_max_len = 10'd64;
        drain(10, 10, 1'b0);

        // Short limit with random downstream stalls.
        i_max_len = 10'd20;
        send_burst(8'h80, 20);
        drain(20, 20, 1'b1);

        // Limit 0 means DEPTH; reset at byte 10 discards the rest.
        i_max_len = 10'd0;
        send_burst(8'hC0, 64);
        drain(64, 10, 1'b0);
        exp_q.delete();
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        check("mid_rst_dval", 16'(o_dval), 16'd0);
        check("mid_rst_dropcnt", o_drop_cnt, 16'd0);
        tick;
        check("post_rst_dval", 16'(o_dval), 16'd0);
        send_burst(8'h11, 3);
        drain(3, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
